// File: rtl/sha2_hash_core.sv
`default_nettype none
// ============================================================================
// Module   : sha2_hash_core
// Brief    : SHA-224/SHA-256 compression engine for pre-padded 512-bit blocks.
//            Runs ROUNDS_PER_CYCLE rounds per clock over a rolling 16-word
//            message schedule. Holds one digest register with a valid/ready
//            handshake and passes a message-ID tag through to the output.
// Revision : 1.0 - initial release
// ============================================================================
module sha2_hash_core #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int ID_WIDTH         = 4
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic [511:0]        data_in,
  input  logic                data_in_last,
  input  logic                data_in_mode,
  input  logic [ID_WIDTH-1:0] data_in_id,
  input  logic                data_in_valid,
  output logic                data_in_ready,
  output logic [255:0]        data_out,
  output logic [ID_WIDTH-1:0] data_out_id,
  output logic                data_out_last,
  output logic                data_out_valid,
  input  logic                data_out_ready
);

  // Reject unsupported configurations at elaboration time
  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4)) begin : g_bad_rounds
    $error("sha2_hash_core: ROUNDS_PER_CYCLE must be 1, 2 or 4");
  end
  if (ID_WIDTH < 1 || ID_WIDTH > 16) begin : g_bad_id_width
    $error("sha2_hash_core: ID_WIDTH must be in 1..16");
  end

  // Round counter value during the final compression cycle of a block
  localparam logic [5:0] c_last_t = 6'(64 - ROUNDS_PER_CYCLE);
  localparam logic [5:0] c_t_step = 6'(ROUNDS_PER_CYCLE);

  localparam logic [0:7][31:0] c_iv256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [0:7][31:0] c_iv224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

  localparam logic [0:63][31:0] c_k = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  typedef enum logic [1:0] {
    S_LOAD     = 2'd0,
    S_COMPRESS = 2'd1,
    S_UPDATE   = 2'd2
  } state_t;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic [0:15][31:0] r_w;          // schedule window, r_w[0] = W[t]
  logic [0:7][31:0]  r_h;          // chaining value H0..H7
  logic [0:7][31:0]  r_wv;         // working variables a..h
  logic [5:0]        r_t;          // round index of the first round this cycle
  logic              r_first;
  logic              r_last;
  logic              r_mode;
  logic [ID_WIDTH-1:0] r_id;

  logic [0:15][31:0] w_win_nxt;
  logic [0:7][31:0]  w_wv_nxt;
  logic [0:7][31:0]  w_sum;
  logic              w_out_free;

  assign w_out_free = !data_out_valid || data_out_ready;

  // Chain ROUNDS_PER_CYCLE rounds and schedule-window shifts combinationally
  always_comb begin : p_rounds
    logic [31:0] v_t1;
    logic [31:0] v_t2;
    logic [31:0] v_new;
    w_wv_nxt  = r_wv;
    w_win_nxt = r_w;
    v_t1      = '0;
    v_t2      = '0;
    v_new     = '0;
    for (int i = 0; i < ROUNDS_PER_CYCLE; i++) begin
      v_t1 = w_wv_nxt[7] + big_sigma1(w_wv_nxt[4])
           + ((w_wv_nxt[4] & w_wv_nxt[5]) ^ (~w_wv_nxt[4] & w_wv_nxt[6]))
           + c_k[r_t + 6'(i)] + w_win_nxt[0];
      v_t2 = big_sigma0(w_wv_nxt[0])
           + ((w_wv_nxt[0] & w_wv_nxt[1]) ^ (w_wv_nxt[0] & w_wv_nxt[2]) ^ (w_wv_nxt[1] & w_wv_nxt[2]));
      w_wv_nxt = {v_t1 + v_t2, w_wv_nxt[0], w_wv_nxt[1], w_wv_nxt[2],
                  w_wv_nxt[3] + v_t1, w_wv_nxt[4], w_wv_nxt[5], w_wv_nxt[6]};
      // Words produced past W[63] are never consumed; generating them keeps the shift uniform
      v_new = small_sigma1(w_win_nxt[14]) + w_win_nxt[9] + small_sigma0(w_win_nxt[1]) + w_win_nxt[0];
      w_win_nxt = {w_win_nxt[1:15], v_new};
    end
  end

  // Feed-forward sum of chaining value and working variables
  always_comb begin : p_sum
    w_sum = '0;
    for (int i = 0; i < 8; i++) begin
      w_sum[i] = r_h[i] + r_wv[i];
    end
  end

  // State register
  always_ff @(posedge clk) begin : p_state
    if (!nrst) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: load, compress for N cycles, then fold/emit
  always_comb begin : p_next_state
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD:     if (data_in_ready && data_in_valid) w_state_nxt = S_COMPRESS;
      S_COMPRESS: if (r_t == c_last_t) w_state_nxt = S_UPDATE;
      S_UPDATE:   if (!r_last || w_out_free) w_state_nxt = S_LOAD;
      default:    w_state_nxt = S_LOAD;
    endcase
  end

  // Datapath, handshake flags and digest register
  always_ff @(posedge clk) begin : p_datapath
    if (!nrst) begin
      data_in_ready  <= 1'b0;
      data_out_valid <= 1'b0;
      data_out_last  <= 1'b0;
      data_out       <= '0;
      data_out_id    <= '0;
      r_t            <= '0;
      r_first        <= 1'b1;
      r_last         <= 1'b0;
      r_mode         <= 1'b0;
      r_id           <= '0;
    end else begin
      // A consumed digest drops valid unless a new one is produced below
      if (data_out_valid && data_out_ready) begin
        data_out_valid <= 1'b0;
      end
      case (r_state)
        S_LOAD: begin
          if (!data_in_ready) begin
            data_in_ready <= 1'b1;
          end else if (data_in_valid) begin
            r_w <= data_in;
            if (r_first) begin
              r_h    <= data_in_mode ? c_iv224 : c_iv256;
              r_wv   <= data_in_mode ? c_iv224 : c_iv256;
              r_mode <= data_in_mode;
              r_id   <= data_in_id;
            end else begin
              r_wv <= r_h;
            end
            r_last        <= data_in_last;
            data_in_ready <= 1'b0;
          end
        end
        S_COMPRESS: begin
          r_wv <= w_wv_nxt;
          r_w  <= w_win_nxt;
          r_t  <= r_t + c_t_step;
        end
        S_UPDATE: begin
          if (!r_last) begin
            r_h           <= w_sum;
            r_first       <= 1'b0;
            data_in_ready <= 1'b1;
          end else if (w_out_free) begin
            data_out       <= r_mode ? {w_sum[0:6], 32'h0} : w_sum;
            data_out_id    <= r_id;
            data_out_valid <= 1'b1;
            data_out_last  <= 1'b1;
            r_first        <= 1'b1;
            data_in_ready  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sha2_hash_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha2_hash_core
// Brief    : Self-checking bench for sha2_hash_core. Three instances
//            (1, 2 and 4 rounds per cycle) share the block inputs and are
//            exercised one at a time: known-answer digests, exact latency,
//            output stall, mid-block reset and random multi-block messages
//            against a 64-word-schedule reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha2_hash_core;

  localparam int NDUT = 3;

  localparam logic [255:0] c_iv256 = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] c_iv224 = 256'hc1059ed8367cd5073070dd17f70e5939ffc00b316858151164f98fa7befa4fa4;
  localparam logic [255:0] c_abc256 = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] c_abc224 = 256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000;
  localparam logic [255:0] c_two256 = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [511:0] c_abc_blk = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] c_two_blk0 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] c_two_blk1 = {480'h0, 32'h000001c0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         nrst;
  logic [511:0] din;
  logic         dlast;
  logic         dmode;
  logic [3:0]   did;
  logic         vld     [NDUT];
  logic         irdy    [NDUT];
  logic [255:0] dout    [NDUT];
  logic [3:0]   doid    [NDUT];
  logic         dolast  [NDUT];
  logic         dovalid [NDUT];
  logic         ordy    [NDUT];

  int checks = 0;
  int errors = 0;
  logic [31:0] kt [64];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    sha2_hash_core #(
      .ROUNDS_PER_CYCLE (1 << g),
      .ID_WIDTH         (4)
    ) u_dut (
      .clk            (clk),
      .nrst           (nrst),
      .data_in        (din),
      .data_in_last   (dlast),
      .data_in_mode   (dmode),
      .data_in_id     (did),
      .data_in_valid  (vld[g]),
      .data_in_ready  (irdy[g]),
      .data_out       (dout[g]),
      .data_out_id    (doid[g]),
      .data_out_last  (dolast[g]),
      .data_out_valid (dovalid[g]),
      .data_out_ready (ordy[g])
    );
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Round constants from the fractional cube roots of the first 64 primes
  task automatic init_k();
    int  p;
    int  cnt;
    bit  isp;
    real x;
    p   = 2;
    cnt = 0;
    while (cnt < 64) begin
      isp = 1'b1;
      for (int d = 2; d * d <= p; d++) if (p % d == 0) isp = 1'b0;
      if (isp) begin
        x = $pow(real'(p), 1.0 / 3.0);
        kt[cnt] = 32'(longint'($floor((x - $floor(x)) * 4294967296.0)));
        cnt++;
      end
      p++;
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook compression: full 64-word expansion, then 64 rounds, then feed-forward
  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0]  w [64];
    logic [31:0]  v [8];
    logic [31:0]  t1;
    logic [31:0]  t2;
    logic [255:0] res;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32 * t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    for (int i = 0; i < 8; i++) v[i] = hin[255 - 32 * i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + kt[t] + w[t];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) res[255 - 32 * i -: 32] = hin[255 - 32 * i -: 32] + v[i];
    return res;
  endfunction

  // Present a block and return at the falling edge right after the handshake edge
  task automatic send_block(input int k, input logic [511:0] d, input bit last, input bit mode, input logic [3:0] id);
    int n;
    n     = 0;
    din   = d;
    dlast = last;
    dmode = mode;
    did   = id;
    vld[k] = 1'b1;
    while (!irdy[k] && n < 500) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    vld[k] = 1'b0;
    chk("send_timeout", 256'(n < 500), 256'(1));
  endtask

  task automatic wait_valid(input int k);
    int n;
    n = 0;
    while (!dovalid[k] && n < 500) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic consume(input int k);
    ordy[k] = 1'b1;
    @(negedge clk);
    ordy[k] = 1'b0;
    chk("consume_valid_low", 256'(dovalid[k]), 256'(0));
  endtask

  task automatic run_random(input int k, input int nmsg);
    logic [511:0] bq [$];
    bit           bl [$];
    bit           bm [$];
    logic [3:0]   bi [$];
    logic [255:0] eq [$];
    logic [3:0]   ei [$];
    logic [255:0] h;
    logic [511:0] blk;
    int           nb;
    bit           mode;
    logic [3:0]   id;
    int           idx;
    int           cyc;
    bit           acc;
    for (int m = 0; m < nmsg; m++) begin
      nb   = $urandom_range(1, 3);
      mode = 1'($urandom_range(0, 1));
      id   = 4'($urandom());
      h    = mode ? c_iv224 : c_iv256;
      for (int b = 0; b < nb; b++) begin
        for (int wi = 0; wi < 16; wi++) blk[511 - 32 * wi -: 32] = $urandom();
        h = compress(h, blk);
        bq.push_back(blk);
        bl.push_back(b == nb - 1);
        bm.push_back((b == 0) ? mode : 1'($urandom_range(0, 1)));
        bi.push_back((b == 0) ? id : 4'($urandom()));
      end
      eq.push_back(mode ? {h[255:32], 32'h0} : h);
      ei.push_back(id);
    end
    idx = 0;
    cyc = 0;
    acc = 1'b0;
    while ((idx < bq.size() || eq.size() > 0) && cyc < 40000) begin
      if (acc) begin
        vld[k] = 1'b0;
        idx++;
        acc = 1'b0;
      end
      ordy[k] = ($urandom_range(0, 3) != 0);
      if (!vld[k] && idx < bq.size() && $urandom_range(0, 2) != 0) begin
        din   = bq[idx];
        dlast = bl[idx];
        dmode = bm[idx];
        did   = bi[idx];
        vld[k] = 1'b1;
      end
      if (dovalid[k]) chk("rand_last", 256'(dolast[k]), 256'(1));
      if (dovalid[k] && ordy[k]) begin
        if (eq.size() == 0) begin
          chk("rand_extra_digest", 256'(1), 256'(0));
        end else begin
          chk("rand_digest", dout[k], eq[0]);
          chk("rand_id", 256'(doid[k]), 256'(ei[0]));
          void'(eq.pop_front());
          void'(ei.pop_front());
        end
      end
      if (vld[k] && irdy[k]) acc = 1'b1;
      @(negedge clk);
      cyc++;
    end
    vld[k]  = 1'b0;
    ordy[k] = 1'b0;
    chk("rand_drain", 256'(eq.size()), 256'(0));
    chk("rand_blocks_sent", 256'(idx), 256'(bq.size()));
  endtask

  initial begin
    init_k();
    nrst  = 1'b0;
    din   = '0;
    dlast = 1'b0;
    dmode = 1'b0;
    did   = '0;
    for (int k = 0; k < NDUT; k++) begin
      vld[k]  = 1'b0;
      ordy[k] = 1'b0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      chk("rst_ready", 256'(irdy[k]), 256'(0));
      chk("rst_valid", 256'(dovalid[k]), 256'(0));
      chk("rst_last", 256'(dolast[k]), 256'(0));
      chk("rst_data", dout[k], 256'(0));
      chk("rst_id", 256'(doid[k]), 256'(0));
    end
    nrst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) chk("rst_ready_rise", 256'(irdy[k]), 256'(1));

    // R=1 SHA-256 "abc", exact 65-edge latency
    send_block(0, c_abc_blk, 1'b1, 1'b0, 4'd3);
    repeat (64) @(negedge clk);
    chk("abc_r1_not_early", 256'(dovalid[0]), 256'(0));
    chk("abc_r1_busy", 256'(irdy[0]), 256'(0));
    @(negedge clk);
    chk("abc_r1_valid", 256'(dovalid[0]), 256'(1));
    chk("abc_r1_digest", dout[0], c_abc256);
    chk("abc_r1_id", 256'(doid[0]), 256'(3));
    chk("abc_r1_last", 256'(dolast[0]), 256'(1));
    consume(0);

    // R=1 SHA-224 "abc"
    send_block(0, c_abc_blk, 1'b1, 1'b1, 4'd9);
    repeat (64) @(negedge clk);
    chk("abc224_not_early", 256'(dovalid[0]), 256'(0));
    @(negedge clk);
    chk("abc224_digest", dout[0], c_abc224);
    chk("abc224_id", 256'(doid[0]), 256'(9));
    consume(0);

    // R=4 two-block message, mode/id changed on block 2 must be ignored
    send_block(2, c_two_blk0, 1'b0, 1'b0, 4'd5);
    repeat (16) @(negedge clk);
    chk("two_r4_blk0_busy", 256'(irdy[2]), 256'(0));
    @(negedge clk);
    chk("two_r4_blk0_ready", 256'(irdy[2]), 256'(1));
    chk("two_r4_no_early_out", 256'(dovalid[2]), 256'(0));
    send_block(2, c_two_blk1, 1'b1, 1'b1, 4'd10);
    repeat (16) @(negedge clk);
    chk("two_r4_not_early", 256'(dovalid[2]), 256'(0));
    @(negedge clk);
    chk("two_r4_valid", 256'(dovalid[2]), 256'(1));
    chk("two_r4_digest", dout[2], c_two256);
    chk("two_r4_id", 256'(doid[2]), 256'(5));
    consume(2);

    // Output held: second message stalls in its final step, then follows with no bubble
    send_block(0, c_abc_blk, 1'b1, 1'b0, 4'd1);
    wait_valid(0);
    chk("stall_first_valid", 256'(dovalid[0]), 256'(1));
    send_block(0, c_abc_blk, 1'b1, 1'b1, 4'd2);
    repeat (200) @(negedge clk);
    chk("stall_hold_valid", 256'(dovalid[0]), 256'(1));
    chk("stall_hold_digest", dout[0], c_abc256);
    chk("stall_hold_id", 256'(doid[0]), 256'(1));
    chk("stall_in_blocked", 256'(irdy[0]), 256'(0));
    ordy[0] = 1'b1;
    @(negedge clk);
    chk("stall_swap_valid", 256'(dovalid[0]), 256'(1));
    chk("stall_swap_digest", dout[0], c_abc224);
    chk("stall_swap_id", 256'(doid[0]), 256'(2));
    chk("stall_swap_ready", 256'(irdy[0]), 256'(1));
    @(negedge clk);
    ordy[0] = 1'b0;
    chk("stall_drained", 256'(dovalid[0]), 256'(0));

    // Reset in the middle of block 1 of a two-block message on R=2
    send_block(1, c_two_blk0, 1'b0, 1'b0, 4'd6);
    repeat (10) @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    for (int k = 0; k < NDUT; k++) begin
      chk("midrst_ready", 256'(irdy[k]), 256'(0));
      chk("midrst_valid", 256'(dovalid[k]), 256'(0));
      chk("midrst_data", dout[k], 256'(0));
      chk("midrst_id", 256'(doid[k]), 256'(0));
      chk("midrst_last", 256'(dolast[k]), 256'(0));
    end
    @(negedge clk);
    chk("midrst_ready_rise", 256'(irdy[1]), 256'(1));
    send_block(1, c_abc_blk, 1'b1, 1'b0, 4'd7);
    repeat (32) @(negedge clk);
    chk("midrst_abc_not_early", 256'(dovalid[1]), 256'(0));
    @(negedge clk);
    chk("midrst_abc_digest", dout[1], c_abc256);
    chk("midrst_abc_id", 256'(doid[1]), 256'(7));
    consume(1);

    // Random multi-block messages with backpressure on every rounds-per-cycle option
    for (int k = 0; k < NDUT; k++) run_random(k, 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
